rs_issue_queue: RTL
===================

Name: rs_issue_queue

Overview:
- Reservation-station storage and select stage for one functional-unit class: ALU, LSU or BRU, chosen by TYPE.
- Receives up to two renamed uops per cycle from dispatch, written into entry indices handed out by the upstream free-slot allocator.
- Tracks source-operand readiness via writeback tag broadcasts and issues the oldest ready uop, one per cycle, to the FU.
- Returns the issued entry index to the free-slot allocator on its issue_free_valid/issue_free input.

Parameters:
- NUM_RS_ENTRIES, 8, number of entries; power of two, at least 4.
- TYPE, 0, unit class: 0=ALU, 1=LSU, 2=BRU. Informational only; no behaviour change.
- PHY_W, 6, physical register tag width. Tag 0 = PHY_ZERO, always ready.
- ROB_W, 5, ROB index width.
- UOP_W, 32, opaque uop payload width (opcode, imm, ctrl).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset; state clears on a rising clk edge while rst=0
- flush  in  1  pipeline flush; invalidates all entries next edge
- disp_valid_0/1  in  1  dispatch lane 0/1 valid; lane 0 is older
- disp_slot_0/1  in  clog2(N)  entry index from free-slot allocator
- disp_uop_0/1  in  UOP_W  payload
- disp_rd_0/1  in  PHY_W  destination tag
- disp_rs1_0/1, disp_rs2_0/1  in  PHY_W  source tags
- disp_rs1_rdy_0/1, disp_rs2_rdy_0/1  in  1  source ready at rename
- disp_rob_0/1  in  ROB_W  ROB index
- wb_valid_0/1  in  1  writeback broadcast valid
- wb_tag_0/1  in  PHY_W  broadcast tag
- issue_valid  out  1  selected entry presented
- issue_ready  in  1  FU accepts
- issue_uop/issue_rd/issue_rs1/issue_rs2/issue_rob  out  payload widths  selected entry fields
- issue_free_valid  out  1  entry freed this cycle
- issue_free  out  clog2(N)+1  freed entry index, zero-extended
- occupancy  out  clog2(N)+1  count of valid entries

Behaviour:
- Reset (rst=0 at edge): all valid bits 0; age matrix 0; occupancy 0. issue_valid, issue_free_valid and issue_free are 0 on the following cycle. Payload outputs are don't-care when issue_valid=0 and drive 0 after reset.
- Entry state: valid, payload, rd, rs1/rs2 tags, rs1_rdy/rs2_rdy, rob.
- Dispatch: on edge with disp_valid_k=1, the entry at disp_slot_k is written with valid=1.
  - Source ready = disp_rsX_rdy_k OR tag==0 OR it matches a valid wb_tag the same cycle (same-cycle bypass).
  - When both lanes fire, the slots differ.
  - Writing a slot that is already valid is a protocol violation; assert in simulation.
- Wakeup: each edge, every valid entry whose rsX tag equals a valid wb_tag_j sets rsX_rdy=1. Two broadcasts are checked in parallel.
- Ready: entry ready = valid & rs1_rdy & rs2_rdy, using registered state only. A broadcast in cycle t makes the entry eligible at t+1.
- Age: N×N matrix, older[j][i]=1 means j is older than i.
  - On dispatch to i: row i is cleared; older[j][i]=1 for every currently valid j not issuing this cycle.
  - With two lanes, lane 0 is marked older than lane 1.
- Select (combinational): the ready entry i with no ready j where older[j][i]=1. issue_valid = any ready. Payload is muxed from the selected entry.
- Fire: issue_valid & issue_ready.
  - issue_free_valid = fire and issue_free = selected index, both combinational in the fire cycle.
  - The entry's valid bit clears at that edge.
  - With issue_ready=0, the selection may change as older entries become ready.
- Occupancy: next = occupancy + dispatches - fire. Dual dispatch plus fire in one cycle nets +1. Never exceeds N.
- Flush: at the edge, all valid bits and the age matrix clear and occupancy goes to 0.
  - During a flush cycle, issue_valid and issue_free_valid are forced to 0.
  - Dispatch in the same cycle is dropped.
  - The allocator is reinitialised by the same flush, not via issue_free.
- Reset has priority over flush; flush has priority over dispatch and issue.

Decomposition:
- parameter_pkg holds:
  - rs_type_e enum (ALU=0, LSU=1, BRU=2)
  - PHY_ZERO constant
  - rs_entry_t packed struct (valid, uop, rd, rs1, rs1_rdy, rs2, rs2_rdy, rob)
- One sub-module, rs_age_select: takes the ready vector and age matrix and outputs the one-hot grant and the encoded index.

Test Plan:
1. Reset then idle: rst=0 for 2 cycles, then rst=1 → issue_valid=0, issue_free_valid=0, occupancy=0.
2. Dual dispatch, all ready: slot0=3 (lane 0) and slot1=5 (lane 1), issue_ready=1.
   - Next cycle: issue from entry 3, issue_free=3.
   - Cycle after: entry 5 issues, issue_free=5; occupancy 2→1→0.
3. Wakeup timing: dispatch rs1=12 not ready; wb_valid_0=1, wb_tag_0=12 in cycle t → issue_valid=1 at t+1, not at t.
4. Same-cycle bypass: dispatch rs2=9, rdy=0, with wb_tag_1=9 in the same cycle → entry issues the next cycle.
5. Age order: fill slots 0..7 with slot 7 oldest and all waiting on tag 20; broadcast 20 → issue order 7,0,1,…,6.
6. Backpressure and flush:
   - issue_ready=0 for 3 cycles → issue_valid held, payload stable, no issue_free.
   - Assert flush → occupancy 0, no issue_free pulse.

Source files
------------

// File: rtl/rs_issue_queue_pkg.sv
// Shared types and constants for the reservation-station issue queue.
// Package only: no timing or flow-control behaviour of its own.
package rs_issue_queue_pkg;

   typedef enum logic [1:0] {
      ALU = 2'd0,
      LSU = 2'd1,
      BRU = 2'd2
   } rs_type_e;

   localparam int RS_PHY_W = 6;
   localparam int RS_ROB_W = 5;
   localparam int RS_UOP_W = 32;

   localparam logic [RS_PHY_W-1:0] PHY_ZERO = '0;

   // Field widths follow the package constants; the top's width parameters must match them.
   typedef struct packed {
      logic                valid;
      logic [RS_UOP_W-1:0] uop;
      logic [RS_PHY_W-1:0] rd;
      logic [RS_PHY_W-1:0] rs1;
      logic                rs1_rdy;
      logic [RS_PHY_W-1:0] rs2;
      logic                rs2_rdy;
      logic [RS_ROB_W-1:0] rob;
   } rs_entry_t;

   function automatic logic tag_hit(
      input logic [RS_PHY_W-1:0] tag,
      input logic                wb_v0,
      input logic [RS_PHY_W-1:0] wb_t0,
      input logic                wb_v1,
      input logic [RS_PHY_W-1:0] wb_t1
   );
      return (wb_v0 && (wb_t0 == tag)) || (wb_v1 && (wb_t1 == tag));
   endfunction

endpackage

// File: rtl/rs_age_select.sv
// Oldest-ready picker: combinational grant from the ready vector and age matrix.
// Zero latency; no flow control, the caller decides whether the grant fires.
module rs_age_select #(
   parameter int N = 8
) (
   input  logic [N-1:0]         ready_i,
   input  logic [N-1:0]         older_i [N],
   output logic [N-1:0]         grant_o,
   output logic [$clog2(N)-1:0] idx_o,
   output logic                 any_o
);

   logic [N-1:0] blocked;

   // An entry loses if any ready entry is recorded as older than it.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         blocked[i] = 1'b0;
         for (int j = 0; j < N; j++) begin
            if (ready_i[j] && older_i[j][i]) begin
               blocked[i] = 1'b1;
            end
         end
      end
   end

   assign grant_o = ready_i & ~blocked;
   assign any_o   = |ready_i;

   always_comb begin
      idx_o = '0;
      for (int i = 0; i < N; i++) begin
         if (grant_o[i]) begin
            idx_o = ($clog2(N))'(i);
         end
      end
   end

endmodule

// File: rtl/rs_issue_queue.sv
// Reservation station: dual dispatch, tag wakeup, oldest-ready issue; issue and free are same-cycle.
// Backpressure: issue_ready=0 holds the selected entry; wakeup is visible one cycle after a broadcast.
module rs_issue_queue
   import rs_issue_queue_pkg::*;
#(
   parameter int NUM_RS_ENTRIES = 8,
   parameter int TYPE           = 0,
   parameter int PHY_W          = RS_PHY_W,
   parameter int ROB_W          = RS_ROB_W,
   parameter int UOP_W          = RS_UOP_W
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              flush,
   input  logic                              disp_valid_0,
   input  logic                              disp_valid_1,
   input  logic [$clog2(NUM_RS_ENTRIES)-1:0] disp_slot_0,
   input  logic [$clog2(NUM_RS_ENTRIES)-1:0] disp_slot_1,
   input  logic [UOP_W-1:0]                  disp_uop_0,
   input  logic [UOP_W-1:0]                  disp_uop_1,
   input  logic [PHY_W-1:0]                  disp_rd_0,
   input  logic [PHY_W-1:0]                  disp_rd_1,
   input  logic [PHY_W-1:0]                  disp_rs1_0,
   input  logic [PHY_W-1:0]                  disp_rs1_1,
   input  logic [PHY_W-1:0]                  disp_rs2_0,
   input  logic [PHY_W-1:0]                  disp_rs2_1,
   input  logic                              disp_rs1_rdy_0,
   input  logic                              disp_rs1_rdy_1,
   input  logic                              disp_rs2_rdy_0,
   input  logic                              disp_rs2_rdy_1,
   input  logic [ROB_W-1:0]                  disp_rob_0,
   input  logic [ROB_W-1:0]                  disp_rob_1,
   input  logic                              wb_valid_0,
   input  logic                              wb_valid_1,
   input  logic [PHY_W-1:0]                  wb_tag_0,
   input  logic [PHY_W-1:0]                  wb_tag_1,
   output logic                              issue_valid,
   input  logic                              issue_ready,
   output logic [UOP_W-1:0]                  issue_uop,
   output logic [PHY_W-1:0]                  issue_rd,
   output logic [PHY_W-1:0]                  issue_rs1,
   output logic [PHY_W-1:0]                  issue_rs2,
   output logic [ROB_W-1:0]                  issue_rob,
   output logic                              issue_free_valid,
   output logic [$clog2(NUM_RS_ENTRIES):0]   issue_free,
   output logic [$clog2(NUM_RS_ENTRIES):0]   occupancy
);

   localparam int N  = NUM_RS_ENTRIES;
   localparam int IW = $clog2(N);

   rs_entry_t    entries_q [N];
   rs_entry_t    entries_d [N];
   logic [N-1:0] older_q [N];
   logic [N-1:0] older_d [N];
   logic [IW:0]  occupancy_q, occupancy_d;

   logic [N-1:0]  ready_vec, grant, survive;
   logic [IW-1:0] sel_idx;
   logic          any_rdy, fire;

   function automatic rs_entry_t new_entry(
      input logic [UOP_W-1:0] uop,
      input logic [PHY_W-1:0] rd,
      input logic [PHY_W-1:0] rs1,
      input logic             rs1_rdy,
      input logic [PHY_W-1:0] rs2,
      input logic             rs2_rdy,
      input logic [ROB_W-1:0] rob
   );
      rs_entry_t e;
      e.valid   = 1'b1;
      e.uop     = uop;
      e.rd      = rd;
      e.rs1     = rs1;
      e.rs1_rdy = rs1_rdy;
      e.rs2     = rs2;
      e.rs2_rdy = rs2_rdy;
      e.rob     = rob;
      return e;
   endfunction

   always_comb begin
      for (int i = 0; i < N; i++) begin
         ready_vec[i] = entries_q[i].valid & entries_q[i].rs1_rdy & entries_q[i].rs2_rdy;
         survive[i]   = entries_q[i].valid & ~(fire & grant[i]);
      end
   end

   rs_age_select #(.N(N)) u_age_select (
      .ready_i (ready_vec),
      .older_i (older_q),
      .grant_o (grant),
      .idx_o   (sel_idx),
      .any_o   (any_rdy)
   );

   assign issue_valid      = any_rdy & ~flush;
   assign fire             = issue_valid & issue_ready;
   assign issue_free_valid = fire;
   assign issue_free       = fire ? {1'b0, sel_idx} : '0;
   assign issue_uop        = entries_q[sel_idx].uop;
   assign issue_rd         = entries_q[sel_idx].rd;
   assign issue_rs1        = entries_q[sel_idx].rs1;
   assign issue_rs2        = entries_q[sel_idx].rs2;
   assign issue_rob        = entries_q[sel_idx].rob;
   assign occupancy        = occupancy_q;

   always_comb begin
      entries_d = entries_q;
      older_d   = older_q;
      for (int i = 0; i < N; i++) begin
         if (tag_hit(entries_q[i].rs1, wb_valid_0, wb_tag_0, wb_valid_1, wb_tag_1)) begin
            entries_d[i].rs1_rdy = 1'b1;
         end
         if (tag_hit(entries_q[i].rs2, wb_valid_0, wb_tag_0, wb_valid_1, wb_tag_1)) begin
            entries_d[i].rs2_rdy = 1'b1;
         end
      end
      if (fire) begin
         entries_d[sel_idx].valid = 1'b0;
      end
      // A new entry is younger than every survivor; lane 0 is also older than lane 1.
      if (disp_valid_0) begin
         entries_d[disp_slot_0] = new_entry(disp_uop_0, disp_rd_0,
            disp_rs1_0, disp_rs1_rdy_0 | (disp_rs1_0 == PHY_ZERO) |
               tag_hit(disp_rs1_0, wb_valid_0, wb_tag_0, wb_valid_1, wb_tag_1),
            disp_rs2_0, disp_rs2_rdy_0 | (disp_rs2_0 == PHY_ZERO) |
               tag_hit(disp_rs2_0, wb_valid_0, wb_tag_0, wb_valid_1, wb_tag_1),
            disp_rob_0);
         older_d[disp_slot_0] = '0;
         for (int j = 0; j < N; j++) begin
            older_d[j][disp_slot_0] = survive[j];
         end
      end
      if (disp_valid_1) begin
         entries_d[disp_slot_1] = new_entry(disp_uop_1, disp_rd_1,
            disp_rs1_1, disp_rs1_rdy_1 | (disp_rs1_1 == PHY_ZERO) |
               tag_hit(disp_rs1_1, wb_valid_0, wb_tag_0, wb_valid_1, wb_tag_1),
            disp_rs2_1, disp_rs2_rdy_1 | (disp_rs2_1 == PHY_ZERO) |
               tag_hit(disp_rs2_1, wb_valid_0, wb_tag_0, wb_valid_1, wb_tag_1),
            disp_rob_1);
         older_d[disp_slot_1] = '0;
         for (int j = 0; j < N; j++) begin
            older_d[j][disp_slot_1] = survive[j] | (disp_valid_0 && (disp_slot_0 == IW'(j)));
         end
      end
      occupancy_d = occupancy_q + (IW+1)'(disp_valid_0) + (IW+1)'(disp_valid_1) - (IW+1)'(fire);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < N; i++) begin
            entries_q[i] <= '0;
            older_q[i]   <= '0;
         end
         occupancy_q <= '0;
      end else if (flush) begin
         for (int i = 0; i < N; i++) begin
            entries_q[i].valid <= 1'b0;
            older_q[i]         <= '0;
         end
         occupancy_q <= '0;
      end else begin
         entries_q   <= entries_d;
         older_q     <= older_d;
         occupancy_q <= occupancy_d;
      end
   end

   always @(posedge clk) begin
      if (rst && !flush) begin
         assert (TYPE <= int'(BRU)) else $error("unsupported unit type %0d", TYPE);
         assert (!(disp_valid_0 && entries_q[disp_slot_0].valid))
            else $error("lane 0 dispatch into occupied slot %0d", disp_slot_0);
         assert (!(disp_valid_1 && entries_q[disp_slot_1].valid))
            else $error("lane 1 dispatch into occupied slot %0d", disp_slot_1);
         assert (!(disp_valid_0 && disp_valid_1 && (disp_slot_0 == disp_slot_1)))
            else $error("both dispatch lanes target slot %0d", disp_slot_0);
      end
   end

endmodule
